periph_bus_bridge: RTL and testbench

Sequential bus master between the multicycle core's load/store port and the address-decoded peripheral bus (RAM, PID1, PID2, ADC, TIM, H7S, PTL). It registers one core request at a time, drives the decoder's `read`/`write`/`addr` inputs, and waits for the selected slave's ready. It then returns read data, steered by the decoder's `read_mux`, together with a one-cycle acknowledge or a bus error. Unmapped addresses and, optionally, unresponsive slaves terminate with an error instead of hanging the core.

---
 rtl/periph_bus_bridge.sv | 188 ++++++++++++++++++
 tb/tb_periph_bus_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge: sequential master between the core load/store port and
// the address-decoded peripheral bus (RAM, PID1, PID2, ADC, TIM, H7S, PTL).
// One access in flight at a time. Each access ends with a one-cycle cpu_ack,
// qualified by cpu_err.
//
// Optional feature macro: PERIPH_BUS_TIMEOUT_EN
//   defined     -> ACCESS gives up after TIMEOUT_CYCLES cycles with cpu_err=1
//   not defined -> ACCESS waits for slv_ready indefinitely
//
// state  | meaning
// IDLE   | waiting for cpu_req; bus strobes low
// ACCESS | strobe held, waiting for decode result / slave ready
// RESP   | cpu_ack high for one cycle with cpu_err/cpu_rdata
module periph_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [6:0]  cs_vec,
  input  logic [2:0]  read_mux,
  input  logic [6:0]  slv_ready,
  input  logic [31:0] rd_ram,
  input  logic [31:0] rd_pid1,
  input  logic [31:0] rd_pid2,
  input  logic [31:0] rd_adc,
  input  logic [31:0] rd_tim,
  input  logic [31:0] rd_h7s,
  input  logic [31:0] rd_ptl
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel_valid;
  logic        sel_ready;
  logic [31:0] sel_data;
  logic        unmapped;
  logic        timeout;

`ifdef PERIPH_BUS_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  assign timeout = (cnt_q == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Steer ready and read data by the decoder's read_mux; 7 has no source.
  always_comb begin
    sel_valid = 1'b1;
    sel_ready = 1'b0;
    sel_data  = 32'h0;
    case (read_mux)
      3'd0: begin sel_ready = slv_ready[0]; sel_data = rd_ram;  end
      3'd1: begin sel_ready = slv_ready[1]; sel_data = rd_pid1; end
      3'd2: begin sel_ready = slv_ready[2]; sel_data = rd_pid2; end
      3'd3: begin sel_ready = slv_ready[3]; sel_data = rd_adc;  end
      3'd4: begin sel_ready = slv_ready[4]; sel_data = rd_tim;  end
      3'd5: begin sel_ready = slv_ready[5]; sel_data = rd_h7s;  end
      3'd6: begin sel_ready = slv_ready[6]; sel_data = rd_ptl;  end
      default: sel_valid = 1'b0;
    endcase
  end

  assign unmapped = (cs_vec == 7'd0) || !sel_valid;

  // State and datapath registers; everything clears on reset, dropping any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
`ifdef PERIPH_BUS_TIMEOUT_EN
      cnt_q   <= 8'h0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      read_q  <= read_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef PERIPH_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and registered-output logic; ack/err/rdata are live only in RESP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    read_d  = read_q;
    write_d = write_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
`ifdef PERIPH_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
          read_d  = ~cpu_we;
          write_d = cpu_we;
`ifdef PERIPH_BUS_TIMEOUT_EN
          cnt_d   = 8'h0;
`endif
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (unmapped || sel_ready || timeout) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
          if (unmapped || !sel_ready) begin
            err_d   = 1'b1;
            rdata_d = we_q ? 32'h0 : ERR_RDATA;
          end else begin
            rdata_d = we_q ? 32'h0 : sel_data;
          end
        end else begin
`ifdef PERIPH_BUS_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign bus_read  = read_q;
  assign bus_write = write_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed bench for periph_bus_bridge with a small address decoder and a
// delayed-ready slave model. Expectations adapt to PERIPH_BUS_TIMEOUT_EN.
module tb_periph_bus_bridge;

  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        bus_read, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [6:0]  cs_vec;
  logic [2:0]  read_mux;
  logic [6:0]  slv_ready;
  logic [31:0] rd_ram  = 32'hCAFE_F00D;
  logic [31:0] rd_pid1 = 32'h1111_1111;
  logic [31:0] rd_pid2 = 32'h2222_2222;
  logic [31:0] rd_adc  = 32'h3333_3333;
  logic [31:0] rd_tim  = 32'h4444_4444;
  logic [31:0] rd_h7s  = 32'h5555_5555;
  logic [31:0] rd_ptl  = 32'h6666_6666;

  int total = 0;
  int bad = 0;
  int ready_delay = 0;
  int scnt = 0;
  logic force_mux7 = 1'b0;
  logic strobe;

  periph_bus_bridge #(.TIMEOUT_CYCLES(16), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .cs_vec(cs_vec), .read_mux(read_mux), .slv_ready(slv_ready),
    .rd_ram(rd_ram), .rd_pid1(rd_pid1), .rd_pid2(rd_pid2), .rd_adc(rd_adc),
    .rd_tim(rd_tim), .rd_h7s(rd_h7s), .rd_ptl(rd_ptl)
  );

  always #5 clk = ~clk;

  assign strobe = bus_read | bus_write;

  always_comb begin
    cs_vec   = 7'd0;
    read_mux = 3'd0;
    if (strobe) begin
      if (bus_addr[31:28] == 4'h1) begin
        cs_vec = 7'b000_0001; read_mux = 3'd0;
      end else if (bus_addr[31:8] == 24'hC0_0000) begin
        case (bus_addr[7:4])
          4'h3: begin cs_vec = 7'b000_0010; read_mux = 3'd1; end
          4'h4: begin cs_vec = 7'b000_0100; read_mux = 3'd2; end
          4'h6: begin cs_vec = 7'b000_1000; read_mux = 3'd3; end
          4'h8: begin cs_vec = 7'b001_0000; read_mux = 3'd4; end
          4'hA: begin cs_vec = 7'b010_0000; read_mux = 3'd5; end
          4'hC: begin cs_vec = 7'b100_0000; read_mux = 3'd6; end
          default: begin cs_vec = 7'd0; read_mux = 3'd0; end
        endcase
      end
      if (force_mux7) begin
        cs_vec = 7'b000_0001; read_mux = 3'd7;
      end
    end
  end

  always @(posedge clk) begin
    if (strobe) scnt <= scnt + 1;
    else        scnt <= 0;
  end

  assign slv_ready = (strobe && ready_delay >= 0 && scnt >= ready_delay) ? cs_vec : 7'd0;

  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int limit, output int lat, output int strb,
                            output logic [31:0] rd, output logic er);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = -1; strb = 0; rd = 32'hx; er = 1'bx;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (strobe) strb++;
      if (cpu_ack) begin
        lat = k; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({cpu_ack, cpu_err, cpu_rdata, bus_read, bus_write, bus_addr, bus_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ack=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h required all 0",
               cpu_ack, cpu_err, cpu_rdata, bus_read, bus_write, bus_addr, bus_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_ram();
    int lat, strb; logic [31:0] rd; logic er;
    ready_delay = 0;
    run_access(1'b0, 32'h1000_0010, 32'h0, 30, lat, strb, rd, er);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL ram_latency got=%0d want=2", lat); end
    total++;
    if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL ram_read err=%b rdata=%h want err=0 rdata=cafef00d", er, rd);
    end
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle ack=%b want 0", cpu_ack); end
  endtask

  task automatic test_write_wait();
    int lat, strb; logic [31:0] rd; logic er;
    ready_delay = 3;
    run_access(1'b1, 32'hC000_0044, 32'hA5A5_0123, 30, lat, strb, rd, er);
    total++;
    if (strb !== 4) begin bad++; $display("FAIL write_strobe_cycles got=%0d want=4", strb); end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL write_latency got=%0d want=5", lat); end
    total++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      bad++; $display("FAIL write_resp err=%b rdata=%h want err=0 rdata=0", er, rd);
    end
    @(negedge clk);
    total++;
    if (bus_addr !== 32'hC000_0044 || bus_wdata !== 32'hA5A5_0123 || strobe !== 1'b0) begin
      bad++; $display("FAIL write_retain addr=%h wdata=%h strobe=%b want c0000044 a5a50123 0",
                      bus_addr, bus_wdata, strobe);
    end
  endtask

  task automatic test_unmapped();
    int lat, strb; logic [31:0] rd; logic er;
    ready_delay = 0;
    run_access(1'b0, 32'h0000_0100, 32'h0, 30, lat, strb, rd, er);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL unmapped_latency got=%0d want=2", lat); end
    total++;
    if (er !== 1'b1 || rd !== ERR_VAL) begin
      bad++; $display("FAIL unmapped_resp err=%b rdata=%h want err=1 rdata=%h", er, rd, ERR_VAL);
    end
    force_mux7 = 1'b1;
    run_access(1'b0, 32'h1000_0020, 32'h0, 30, lat, strb, rd, er);
    force_mux7 = 1'b0;
    total++;
    if (lat !== 2 || er !== 1'b1 || rd !== ERR_VAL) begin
      bad++; $display("FAIL mux7_resp lat=%0d err=%b rdata=%h want 2 1 %h", lat, er, rd, ERR_VAL);
    end
  endtask

  task automatic test_timeout();
    int lat, strb; logic [31:0] rd; logic er;
    ready_delay = -1;
`ifdef PERIPH_BUS_TIMEOUT_EN
    run_access(1'b0, 32'hC000_0080, 32'h0, 40, lat, strb, rd, er);
    total++;
    if (lat !== 17) begin bad++; $display("FAIL timeout_latency got=%0d want=17", lat); end
    total++;
    if (er !== 1'b1 || rd !== ERR_VAL) begin
      bad++; $display("FAIL timeout_resp err=%b rdata=%h want err=1 rdata=%h", er, rd, ERR_VAL);
    end
    total++;
    if (strobe !== 1'b0) begin bad++; $display("FAIL timeout_strobe_low strobe=%b want 0", strobe); end
`else
    run_access(1'b0, 32'hC000_0080, 32'h0, 100, lat, strb, rd, er);
    total++;
    if (lat !== -1) begin bad++; $display("FAIL no_timeout_ack got ack at %0d want none", lat); end
    total++;
    if (bus_read !== 1'b1) begin bad++; $display("FAIL no_timeout_strobe bus_read=%b want 1", bus_read); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_ack, bus_read, bus_write} !== 3'b000) begin
      bad++; $display("FAIL stuck_reset ack=%b rd=%b wr=%b want 0", cpu_ack, bus_read, bus_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_access();
    int lat, strb; logic [31:0] rd; logic er;
    ready_delay = -1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0080;
    repeat (3) @(negedge clk);
    cpu_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_ack, cpu_err, cpu_rdata, bus_read, bus_write, bus_addr, bus_wdata} !== '0) begin
      bad++;
      $display("FAIL midaccess_reset ack=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h required all 0",
               cpu_ack, cpu_err, cpu_rdata, bus_read, bus_write, bus_addr, bus_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_delay = 0;
    run_access(1'b0, 32'hC000_00A8, 32'h0, 30, lat, strb, rd, er);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h5555_5555) begin
      bad++; $display("FAIL h7s_after_reset lat=%0d err=%b rdata=%h want 2 0 55555555", lat, er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0;
    int t[2];
    logic [31:0] d[2];
    ready_delay = 0;
    t[0] = -1; t[1] = -1; d[0] = 32'h0; d[1] = 32'h0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0030;
    for (int k = 1; k <= 20 && n_ack < 2; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        t[n_ack] = k; d[n_ack] = cpu_rdata;
        n_ack++;
        cpu_addr = 32'hC000_00C0;
      end
    end
    cpu_req = 1'b0;
    total++;
    if (t[0] !== 2 || d[0] !== 32'h1111_1111) begin
      bad++; $display("FAIL b2b_pid1 at=%0d rdata=%h want 2 11111111", t[0], d[0]);
    end
    total++;
    if (t[1] !== 5 || d[1] !== 32'h6666_6666) begin
      bad++; $display("FAIL b2b_ptl at=%0d rdata=%h want 5 66666666", t[1], d[1]);
    end
  endtask

  initial begin
    test_reset();
    test_read_ram();
    test_write_wait();
    test_unmapped();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
